// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and defaults for the data-memory arbiter
//
// Purpose: holds the FSM state type and the default burst/starvation limits.
// The arbiter and anything that needs to decode its state import this package.
// Ports: none (package).

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_ACC    = 2'd2
    } arb_state_t;

    localparam int DEF_MAX_BURST    = 16;
    localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between CPU MEM stage and CNN accelerator
//
// Purpose: shares one synchronous single-port data memory between the CPU
// load/store path and a bursting accelerator. The CPU normally has priority in
// IDLE. An accelerator that has been denied STARVE_LIMIT IDLE cycles in a row
// takes priority. An accelerator burst is capped at MAX_BURST beats.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU MEM-stage access request
//   cpu_rdata, cpu_stall       CPU load data, pipeline hold
//   acc_req/we/addr/wdata/last accelerator beat request
//   acc_gnt                    beat accepted when acc_req && acc_gnt
//   acc_rvalid, acc_rdata      accelerator read return (one cycle after issue)
//   mem_en/we/addr/wdata       memory strobe and command (combinational)
//   mem_rdata                  memory read data, valid the cycle after a read

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        acc_req,
    input  logic        acc_we,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    input  logic        acc_last,
    output logic        acc_gnt,
    output logic        acc_rvalid,
    output logic [31:0] acc_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] C_MAX_BURST    = BW'(MAX_BURST);
    localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

    arb_state_t    r_state;
    logic [BW-1:0] r_beat_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic          r_acc_rvalid;
    logic [31:0]   r_hold;

    logic          w_in_idle;
    logic          w_acc_wins;
    logic          w_cpu_wins;
    logic          w_acc_beat;
    logic          w_cpu_issue;
    logic [BW-1:0] w_beat_next;

    always_comb begin
        w_in_idle   = (r_state == ST_IDLE);
        // Accelerator takes IDLE only when the CPU is quiet or it has starved.
        w_acc_wins  = w_in_idle && acc_req &&
                      (!cpu_req || (r_starve_cnt == C_STARVE_LIMIT));
        w_cpu_wins  = w_in_idle && cpu_req && !w_acc_wins;
        // Everything that reaches the memory is gated by reset so the strobe
        // drops the instant reset rises, not at the next edge.
        w_acc_beat  = !reset && (w_acc_wins || ((r_state == ST_ACC) && acc_req));
        w_cpu_issue = !reset && w_cpu_wins;
        w_beat_next = r_beat_cnt + BW'(1);
    end

    always_comb begin
        mem_en     = w_acc_beat || w_cpu_issue;
        mem_we     = (w_acc_beat && acc_we) || (w_cpu_issue && cpu_we);
        mem_addr   = w_acc_beat ? acc_addr  : cpu_addr;
        mem_wdata  = w_acc_beat ? acc_wdata : cpu_wdata;
        acc_gnt    = !reset && (w_acc_wins || (r_state == ST_ACC));
        cpu_stall  = !reset && cpu_req &&
                     ((r_state == ST_ACC) || (w_in_idle && (w_acc_wins || !cpu_we)));
        cpu_rdata  = (r_state == ST_CPU_RD) ? mem_rdata : r_hold;
        acc_rvalid = r_acc_rvalid;
        acc_rdata  = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
            r_acc_rvalid <= 1'b0;
            r_hold       <= '0;
        end else begin
            // Read return is tagged by the issuing owner: only accelerator
            // reads raise rvalid, a CPU read returns through CPU_RD instead.
            r_acc_rvalid <= w_acc_beat && !acc_we;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_wins) begin
                        r_beat_cnt   <= BW'(1);
                        r_starve_cnt <= '0;
                        if (!acc_last && (MAX_BURST > 1)) begin
                            r_state <= ST_ACC;
                        end
                    end else begin
                        if (!acc_req) begin
                            r_starve_cnt <= '0;
                        end else if (cpu_req && (r_starve_cnt != C_STARVE_LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + SW'(1);
                        end
                        if (cpu_req && !cpu_we) begin
                            r_state <= ST_CPU_RD;
                        end
                    end
                end
                ST_CPU_RD: begin
                    r_hold  <= mem_rdata;
                    r_state <= ST_IDLE;
                    if (!acc_req) begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_ACC: begin
                    if (!acc_req) begin
                        r_state      <= ST_IDLE;
                        r_starve_cnt <= '0;
                    end else begin
                        r_beat_cnt <= w_beat_next;
                        if (acc_last || (w_beat_next == C_MAX_BURST)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural reference model

module tb_dmem_arbiter;

    localparam int MAXB = 16;
    localparam int SLIM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        acc_req, acc_we, acc_last;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_gnt, acc_rvalid;
    logic [31:0] acc_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MAXB), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_last(acc_last), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory, 256 words.
    logic [31:0] tb_mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[9:2]];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the memory, how many beats the current burst
    // has used, how long the accelerator has waited, and a shadow memory.
    int          m_owner;      // 0 free, 1 CPU load returning, 2 accelerator burst
    int          m_beats;
    int          m_wait;
    logic [31:0] m_hold, m_cpu_ret, m_acc_ret;
    logic        m_rv;
    logic [31:0] shadow [0:255];

    logic o_gnt, o_stall, o_en, o_we, o_rv;
    logic [31:0] o_crd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_beats = 0; m_wait = 0;
        m_hold = 0; m_cpu_ret = 0; m_acc_ret = 0; m_rv = 1'b0;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                        input logic al);
        logic acc_first, cpu_first, acc_go, cpu_go;
        logic e_gnt, e_en, e_we, e_stall;
        logic [31:0] e_addr, e_wdata, e_crd;
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        acc_req = ar; acc_we = aw; acc_addr = aa; acc_wdata = ad; acc_last = al;
        #1;
        acc_first = (m_owner == 0) && ar && (!cr || m_wait == SLIM);
        cpu_first = (m_owner == 0) && cr && !acc_first;
        acc_go    = acc_first || (m_owner == 2 && ar);
        cpu_go    = cpu_first;
        e_gnt     = acc_first || (m_owner == 2);
        e_en      = acc_go || cpu_go;
        e_we      = (acc_go && aw) || (cpu_go && cw);
        e_addr    = acc_go ? aa : ca;
        e_wdata   = acc_go ? ad : cd;
        // CPU is held whenever it asks and does not get a store done right now.
        e_stall   = cr && (m_owner == 2 || (m_owner == 0 && !(cpu_first && cw)));
        e_crd     = (m_owner == 1) ? m_cpu_ret : m_hold;

        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        chk("acc_gnt", acc_gnt, e_gnt);
        chk("cpu_stall", cpu_stall, e_stall);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("acc_rvalid", acc_rvalid, m_rv);
        if (m_rv) chk("acc_rdata", acc_rdata, m_acc_ret);
        o_gnt = acc_gnt; o_stall = cpu_stall; o_en = mem_en; o_we = mem_we;
        o_rv = acc_rvalid; o_crd = cpu_rdata;

        // Advance the model to the state after the coming rising edge.
        if (m_owner == 1) m_hold = m_cpu_ret;
        if (acc_go && !aw) m_acc_ret = shadow[aa[9:2]];
        if (cpu_go && !cw) m_cpu_ret = shadow[ca[9:2]];
        m_rv = acc_go && !aw;
        if (e_we) shadow[e_addr[9:2]] = e_wdata;

        if (!ar || acc_first) m_wait = 0;
        else if (cpu_first && m_wait < SLIM) m_wait++;

        if (m_owner == 1) begin
            m_owner = 0;
        end else if (m_owner == 0) begin
            if (acc_first) begin
                m_beats = 1;
                m_owner = (al || MAXB == 1) ? 0 : 2;
            end else if (cpu_first && !cw) begin
                m_owner = 1;
            end
        end else begin
            if (!ar) m_owner = 0;
            else begin
                m_beats++;
                if (al || m_beats >= MAXB) m_owner = 0;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int gcnt, rvcnt, first_win, beats_before, served_at;
        logic pend;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        acc_req = 0; acc_we = 0; acc_addr = 0; acc_wdata = 0; acc_last = 0;
        model_reset();

        // Reset state, with requests asserted to show the outputs stay quiet.
        repeat (2) @(negedge clk);
        cpu_req = 1; acc_req = 1;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_acc_gnt", acc_gnt, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_acc_rvalid", acc_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        @(negedge clk);
        cpu_req = 0; acc_req = 0;
        reset = 1'b0;

        // CPU store then load.
        step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("store_we", o_we, 1);
        chk("store_stall", o_stall, 0);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("load_stall_issue", o_stall, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("load_stall_ret", o_stall, 0);
        chk("load_data", o_crd, 32'hDEADBEEF);
        idle();
        chk("load_hold", o_crd, 32'hDEADBEEF);

        // Preload burst data.
        for (int i = 0; i < 4; i++)
            step(1, 1, 32'h100 + 4 * i, 32'hA5000000 + i, 0, 0, 0, 0, 0);

        // Four-beat accelerator read burst, CPU idle.
        gcnt = 0; rvcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(0, 0, 0, 0, 1, 0, 32'h100 + 4 * i, 0, i == 3);
            else       idle();
            if (o_gnt) gcnt++;
            if (i == 0) chk("burst_rv_c1", o_rv, 0);
            else if (o_rv) rvcnt++;
        end
        chk("burst_gnt_cycles", gcnt, 4);
        chk("burst_rv_cycles", rvcnt, 4);
        chk("burst_back_idle", o_gnt, 0);

        // Endless burst with a CPU load waiting: cap at MAX_BURST beats.
        pend = 0; beats_before = 0; served_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) pend = 1;
            step(pend, 0, 32'h10, 0, 1, 0, 32'h200 + 4 * (c % 32), 0, 0);
            if (served_at < 0 && o_gnt) beats_before++;
            if (pend && c >= 1 && !o_stall) begin
                served_at = c;
                pend = 0;
                chk("capped_load_data", o_crd, 32'hDEADBEEF);
            end
        end
        chk("burst_cap_beats", beats_before, MAXB);
        chk("cpu_wait_bound", (served_at >= 1 && served_at - 1 <= MAXB + 1), 1);
        idle();
        idle();

        // Both requesting continuously: accelerator wins after SLIM denials.
        first_win = -1;
        for (int c = 0; c < 12; c++) begin
            step(1, 1, 32'h20, 32'h1000 + c, 1, 0, 32'h300, 0, 1);
            if (first_win < 0 && o_gnt) first_win = c;
            else if (first_win >= 0 && c == first_win + 1) chk("starve_cleared", o_gnt, 0);
        end
        chk("starve_win_cycle", first_win, SLIM);
        idle();

        // Reset during beat 3 of a read burst.
        step(0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h104, 0, 0);
        @(negedge clk);
        acc_addr = 32'h108;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_acc_gnt", acc_gnt, 0);
        chk("midrst_acc_rvalid", acc_rvalid, 0);
        chk("midrst_cpu_stall", cpu_stall, 0);
        @(negedge clk);
        acc_req = 0;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            chk("post_rst_no_rv", o_rv, 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 3) == 0, $urandom % 2, {22'h0, 8'($urandom), 2'b00}, $urandom,
                 ($urandom % 3) != 0, $urandom % 2, {22'h0, 8'($urandom), 2'b00}, $urandom,
                 ($urandom % 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
  MAX_BURST, 16, max accelerator beats per grant before forced release
  STARVE_LIMIT, 8, consecutive denied IDLE cycles after which accelerator wins priority
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock; all state on rising edge
  reset  in  1  asynchronous, active-high reset
  cpu_req  in  1  MEM-stage load/store valid
  cpu_we  in  1  store (MemWriteM)
  cpu_addr  in  32  byte address
  cpu_wdata  in  32  store data
  cpu_rdata  out  32  load data
  cpu_stall  out  1  holds pipeline (F/D/E/M) when high
  acc_req  in  1  CNN accelerator beat valid
  acc_we  in  1  accelerator write
  acc_addr  in  32  accelerator address
  acc_wdata  in  32  accelerator write data
  acc_last  in  1  final beat of burst
  acc_gnt  out  1  beat accepted when acc_req && acc_gnt
  acc_rvalid  out  1  accelerator read data valid
  acc_rdata  out  32  accelerator read data
  mem_en, mem_we  out  1 each  single-port data memory strobe / write enable
  mem_addr, mem_wdata  out  32 each  memory address / write data
  mem_rdata  in  32  synchronous read data, valid cycle after read issue

Function
REQ-003 SHALL implement FSM states IDLE, CPU_RD, ACC.
REQ-004 In IDLE, CPU SHALL win when cpu_req=1, unless starve_cnt==STARVE_LIMIT and acc_req=1, in which case accelerator wins.
REQ-005 CPU win, store: mem_en=mem_we=1 with cpu_addr/cpu_wdata same cycle; cpu_stall=0; stay IDLE.
REQ-006 CPU win, load: mem_en=1, mem_we=0, cpu_stall=1; next state CPU_RD.
REQ-007 CPU_RD: cpu_stall=0, cpu_rdata=mem_rdata (combinational), captured into hold register; no memory issue; cpu_req ignored; next state IDLE.
REQ-008 Outside CPU_RD, cpu_rdata SHALL equal hold register (last CPU load value; 0 after reset).
REQ-009 Accelerator win in IDLE: acc_gnt=1, beat issued same cycle, beat_cnt<=1; next state ACC unless acc_last=1 or MAX_BURST==1 (stay IDLE).
REQ-010 ACC: acc_gnt=1; each beat with acc_req=1 issues to memory and increments beat_cnt; exit to IDLE on beat with acc_last=1 or when beat_cnt reaches MAX_BURST; exit to IDLE on any cycle with acc_req=0 (no issue).
REQ-011 cpu_stall SHALL be 1 when cpu_req=1 in ACC, and when cpu_req=1 in IDLE while CPU loses or issues a load; otherwise 0.
REQ-012 acc_rvalid SHALL be registered: 1 exactly one cycle after each accepted accelerator read beat, independent of FSM state; acc_rdata=mem_rdata.
REQ-013 starve_cnt (saturating at STARVE_LIMIT) SHALL increment per IDLE cycle with acc_req=1 and CPU winning; clear when accelerator wins or acc_req=0.
REQ-014 Back-to-back: CPU load issued in cycle after last accelerator read beat SHALL not corrupt either return (rvalid tag routes by issue owner).
REQ-015 mem_en SHALL be 0 in any cycle with no granted access; mem_* outputs combinational from selected requester.
REQ-016 Worst-case CPU wait SHALL be bounded by MAX_BURST+1 cycles.

Reset
REQ-017 reset SHALL asynchronously force IDLE, beat_cnt=0, starve_cnt=0, acc_rvalid=0, hold register=0; mem_en, mem_we, acc_gnt, cpu_stall SHALL be 0 while reset is high.
REQ-018 Reset mid-burst or mid-load SHALL abandon the transaction; no acc_rvalid after release.

Structure
REQ-019 State encodings and MAX_BURST/STARVE_LIMIT defaults SHALL live in shared package dmem_arb_pkg.
REQ-020 Design SHALL be flat; no sub-module.

Verification
REQ-021 CPU store addr 0x10 data 0xDEADBEEF, acc idle -> mem_we=1 same cycle, cpu_stall=0 throughout.
REQ-022 CPU load 0x10 -> cpu_stall=1 one cycle, then cpu_rdata=0xDEADBEEF with cpu_stall=0.
REQ-023 Accelerator 4-beat read burst at 0x100 (acc_last on beat 4), CPU idle -> acc_gnt 4 cycles, acc_rvalid cycles 2-5, back to IDLE.
REQ-024 Accelerator holds acc_req with no acc_last for 40 cycles, CPU load pending -> release after 16 beats, CPU served within 17 cycles.
REQ-025 cpu_req and acc_req continuously high -> accelerator wins after 8 denied cycles, starve_cnt clears.
REQ-026 Assert reset during beat 3 of a burst -> outputs zero immediately, IDLE after release, no stray acc_rvalid.
